// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for rv_decode_stage.
// The stage uses the slave view; the fetch/execute environment uses the master view.
interface rv_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic             flush;
    logic             drain_done;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic             out_reg_write;
    logic             out_alu_src;
    logic             out_mem_write;
    logic             out_mem_read;
    logic             out_branch;
    logic             out_jump;
    logic             out_op1_src;
    logic             out_csr_write;
    logic             out_is_ecall;
    logic             out_is_ebreak;
    logic             out_illegal;
    logic             out_serial;
    logic [1:0]       out_mem_to_reg;
    logic [2:0]       out_alu_op;

    modport master (
        output flush, drain_done, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_reg_write, out_alu_src, out_mem_write,
               out_mem_read, out_branch, out_jump, out_op1_src, out_csr_write,
               out_is_ecall, out_is_ebreak, out_illegal, out_serial,
               out_mem_to_reg, out_alu_op
    );

    modport slave (
        input  flush, drain_done, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_reg_write, out_alu_src, out_mem_write,
               out_mem_read, out_branch, out_jump, out_op1_src, out_csr_write,
               out_is_ecall, out_is_ebreak, out_illegal, out_serial,
               out_mem_to_reg, out_alu_op
    );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32/RV64 decode stage: base-ISA control decode and immediates,
// two-entry skid buffer, and a RUN/HOLD/DRAIN serialiser for SYSTEM, FENCE and illegal ops.
module rv_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          EN_M     = 1'b1,
    parameter bit          EN_ZICSR = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    rv_decode_stage_if.slave bus
);

    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            mem_read;
        logic            branch;
        logic            jump;
        logic            op1_src;
        logic            csr_write;
        logic            is_ecall;
        logic            is_ebreak;
        logic            illegal;
        logic            serial;
        logic [1:0]      mem_to_reg;
        logic [2:0]      alu_op;
    } uop_t;

    logic [31:0]     instr;
    logic [4:0]      opc;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bus.in_instr;
    assign opc    = instr[6:2];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Sign-extending size casts cover both the RV32 and RV64 widths.
    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    uop_t     dec;
    imm_fmt_t fmt;
    logic     bad;

    always_comb begin
        // NOTE: every variable gets a default before the case tree, so no path can infer a latch.
        dec        = '0;
        fmt        = IMM_NONE;
        bad        = 1'b0;
        dec.pc     = bus.in_pc;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = funct3;
        dec.funct7 = funct7;

        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opc)
                OPC_OP: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 3'b010;
                    bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                            (EN_M && funct7 == 7'b0000001));
                end
                OPC_OP_IMM: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 3'b011;
                    fmt           = IMM_I;
                end
                OPC_LOAD: begin
                    dec.alu_src    = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 2'b01;
                    fmt            = IMM_I;
                end
                OPC_STORE: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    fmt           = IMM_S;
                end
                OPC_BRANCH: begin
                    dec.branch  = 1'b1;
                    dec.alu_src = 1'b1;
                    dec.alu_op  = 3'b001;
                    fmt         = IMM_B;
                end
                OPC_JAL: begin
                    dec.jump       = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.op1_src    = 1'b1;
                    dec.mem_to_reg = 2'b10;
                    fmt            = IMM_J;
                end
                OPC_JALR: begin
                    dec.jump       = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 2'b10;
                    fmt            = IMM_I;
                end
                OPC_LUI: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 3'b101;
                    fmt           = IMM_U;
                end
                OPC_AUIPC: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.op1_src   = 1'b1;
                    fmt           = IMM_U;
                end
                OPC_MISC_MEM: dec.serial = 1'b1;
                OPC_SYSTEM: begin
                    dec.serial = 1'b1;
                    if (funct3 == 3'b000) begin
                        if (instr[31:20] == 12'd0)      dec.is_ecall  = 1'b1;
                        else if (instr[31:20] == 12'd1) dec.is_ebreak = 1'b1;
                        else                            bad           = 1'b1;
                    end else if (funct3 == 3'b100 || !EN_ZICSR) begin
                        bad = 1'b1;
                    end else begin
                        dec.csr_write = 1'b1;
                        dec.reg_write = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
        end

        case (fmt)
            IMM_I:   dec.imm = imm_i;
            IMM_S:   dec.imm = imm_s;
            IMM_B:   dec.imm = imm_b;
            IMM_U:   dec.imm = imm_u;
            IMM_J:   dec.imm = imm_j;
            default: dec.imm = '0;
        endcase

        // Illegal words carry only their register fields, the illegal flag and the serialise request.
        if (bad) begin
            dec.imm        = '0;
            dec.reg_write  = 1'b0;
            dec.alu_src    = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
            dec.op1_src    = 1'b0;
            dec.csr_write  = 1'b0;
            dec.is_ecall   = 1'b0;
            dec.is_ebreak  = 1'b0;
            dec.mem_to_reg = 2'b00;
            dec.alu_op     = 3'b000;
            dec.illegal    = 1'b1;
            dec.serial     = 1'b1;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    state_t state, state_nxt;
    uop_t   main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   in_fire, out_fire;

    assign bus.in_ready = rst_n & (state == RUN) & ~skid_valid;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign out_fire     = main_valid & bus.out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (in_fire && dec.serial)     state_nxt = HOLD;
            HOLD:    if (out_fire && main_q.serial) state_nxt = DRAIN;
            DRAIN:   if (bus.drain_done)            state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: the payload registers are reset as well, because the outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            state      <= RUN;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (!main_valid || bus.out_ready) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign bus.out_valid      = main_valid;
    assign bus.out_pc         = main_q.pc;
    assign bus.out_imm        = main_q.imm;
    assign bus.out_rs1        = main_q.rs1;
    assign bus.out_rs2        = main_q.rs2;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_funct3     = main_q.funct3;
    assign bus.out_funct7     = main_q.funct7;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_alu_src    = main_q.alu_src;
    assign bus.out_mem_write  = main_q.mem_write;
    assign bus.out_mem_read   = main_q.mem_read;
    assign bus.out_branch     = main_q.branch;
    assign bus.out_jump       = main_q.jump;
    assign bus.out_op1_src    = main_q.op1_src;
    assign bus.out_csr_write  = main_q.csr_write;
    assign bus.out_is_ecall   = main_q.is_ecall;
    assign bus.out_is_ebreak  = main_q.is_ebreak;
    assign bus.out_illegal    = main_q.illegal;
    assign bus.out_serial     = main_q.serial;
    assign bus.out_mem_to_reg = main_q.mem_to_reg;
    assign bus.out_alu_op     = main_q.alu_op;

endmodule
